// File: rtl/core_pkg.sv
// Shared types and defaults for the core decode/execute pipeline.
package core_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        IMM_Z    = 4'd0,
        IMM_I    = 4'd1,
        IMM_S    = 4'd2,
        IMM_B    = 4'd3,
        IMM_U    = 4'd4,
        IMM_J    = 4'd5,
        IMM_CSR  = 4'd6,
        IMM_CI   = 4'd7,
        IMM_CLUI = 4'd8,
        IMM_CJ   = 4'd9,
        IMM_CB   = 4'd10
    } imm_type_e;

endpackage

// File: rtl/core_imm_decode.sv
// Combinational immediate extraction for base and compressed RISC-V formats.
module core_imm_decode
    import core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter bit EN_RVC = 1'b1
) (
    input  logic [31:0]     instr,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [31:0] imm32;
    logic        unused_opcode_bits;

    assign unused_opcode_bits = ^instr[1:0];

    // Every format is built as a sign-correct 32-bit value, then widened once.
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (imm_type)
            IMM_Z:   imm32 = '0;
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            IMM_CSR: imm32 = {27'b0, instr[19:15]};
            IMM_CI: begin
                if (EN_RVC) imm32 = {{26{instr[12]}}, instr[12], instr[6:2]};
                else        illegal = 1'b1;
            end
            IMM_CLUI: begin
                if (EN_RVC) imm32 = {{14{instr[12]}}, instr[12], instr[6:2], 12'b0};
                else        illegal = 1'b1;
            end
            IMM_CJ: begin
                if (EN_RVC) imm32 = {{20{instr[12]}}, instr[12], instr[8], instr[10:9],
                                     instr[6], instr[7], instr[2], instr[11],
                                     instr[5:3], 1'b0};
                else        illegal = 1'b1;
            end
            IMM_CB: begin
                if (EN_RVC) imm32 = {{23{instr[12]}}, instr[12], instr[6:5], instr[2],
                                     instr[11:10], instr[4:3], 1'b0};
                else        illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_wide
            assign imm = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_narrow
            assign imm = imm32;
        end
    endgenerate

endmodule

// File: rtl/core_imm_stage.sv
// Registered immediate stage: decode on input, output register plus skid register.
module core_imm_stage
    import core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter bit EN_RVC = 1'b1,
    parameter int TAG_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  imm_type_e        in_imm_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;
    logic             in_fire;
    logic             out_fire;

    logic             out_vld_q,  out_vld_d;
    logic [XLEN-1:0]  out_imm_q,  out_imm_d;
    logic             out_ill_q,  out_ill_d;
    logic [TAG_W-1:0] out_tag_q,  out_tag_d;
    logic             skid_vld_q, skid_vld_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic             skid_ill_q, skid_ill_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

    core_imm_decode #(
        .XLEN   (XLEN),
        .EN_RVC (EN_RVC)
    ) u_decode (
        .instr    (in_instr),
        .imm_type (in_imm_type),
        .imm      (dec_imm),
        .illegal  (dec_illegal)
    );

    // in_ready depends only on the skid flop, never on out_ready.
    assign in_ready = ~skid_vld_q;
    assign in_fire  = in_valid & ~skid_vld_q;
    assign out_fire = out_vld_q & out_ready;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_imm_d  = out_imm_q;
        out_ill_d  = out_ill_q;
        out_tag_d  = out_tag_q;
        skid_vld_d = skid_vld_q;
        skid_imm_d = skid_imm_q;
        skid_ill_d = skid_ill_q;
        skid_tag_d = skid_tag_q;
        if (flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!out_vld_q || out_fire) begin
            // Output slot frees up: skid entry is older, so it goes first.
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_imm_d  = skid_imm_q;
                out_ill_d  = skid_ill_q;
                out_tag_d  = skid_tag_q;
                skid_vld_d = 1'b0;
            end else if (in_fire) begin
                out_vld_d = 1'b1;
                out_imm_d = dec_imm;
                out_ill_d = dec_illegal;
                out_tag_d = in_tag;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_vld_d = 1'b1;
            skid_imm_d = dec_imm;
            skid_ill_d = dec_illegal;
            skid_tag_d = in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_imm_q  <= '0;
            out_ill_q  <= 1'b0;
            out_tag_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_imm_q <= '0;
            skid_ill_q <= 1'b0;
            skid_tag_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_imm_q  <= out_imm_d;
            out_ill_q  <= out_ill_d;
            out_tag_q  <= out_tag_d;
            skid_vld_q <= skid_vld_d;
            skid_imm_q <= skid_imm_d;
            skid_ill_q <= skid_ill_d;
            skid_tag_q <= skid_tag_d;
        end
    end

    assign out_valid   = out_vld_q;
    assign out_imm     = out_imm_q;
    assign out_illegal = out_ill_q;
    assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_core_imm_stage.sv
// Directed and soak checks of core_imm_stage across XLEN and EN_RVC variants.
module tb_core_imm_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    imm_type_e   in_imm_type;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm;
    logic [7:0]  a_out_tag;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm;
    logic [7:0]  b_out_tag;
    logic        c_in_ready, c_out_valid, c_out_illegal;
    logic [63:0] c_out_imm;
    logic [7:0]  c_out_tag;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    core_imm_stage #(.XLEN(32), .EN_RVC(1'b1), .TAG_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
        .out_illegal(a_out_illegal), .out_tag(a_out_tag)
    );
    core_imm_stage #(.XLEN(64), .EN_RVC(1'b1), .TAG_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
        .out_illegal(b_out_illegal), .out_tag(b_out_tag)
    );
    core_imm_stage #(.XLEN(64), .EN_RVC(1'b0), .TAG_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_instr(in_instr), .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_imm(c_out_imm),
        .out_illegal(c_out_illegal), .out_tag(c_out_tag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one entry with out_ready=1 and check all three variants one cycle later.
    task automatic send_chk(input string nm, input imm_type_e t, input logic [31:0] instr,
                            input logic [7:0] tag,
                            input logic [63:0] e32, input logic il32,
                            input logic [63:0] e64, input logic il64,
                            input logic [63:0] e64n, input logic il64n);
        in_valid    = 1'b1;
        in_imm_type = t;
        in_instr    = instr;
        in_tag      = tag;
        out_ready   = 1'b1;
        tick();
        in_valid = 1'b0;
        $display("txn %s type=%0d instr=%h tag=%h a=%h b=%h c=%h", nm, t, instr, tag,
                 a_out_imm, b_out_imm, c_out_imm);
        check({nm, "_a_vld"}, 64'(a_out_valid), 64'd1);
        check({nm, "_a_imm"}, 64'(a_out_imm), e32);
        check({nm, "_a_ill"}, 64'(a_out_illegal), 64'(il32));
        check({nm, "_a_tag"}, 64'(a_out_tag), 64'(tag));
        check({nm, "_b_imm"}, b_out_imm, e64);
        check({nm, "_b_ill"}, 64'(b_out_illegal), 64'(il64));
        check({nm, "_c_vld"}, 64'(c_out_valid), 64'd1);
        check({nm, "_c_imm"}, c_out_imm, e64n);
        check({nm, "_c_ill"}, 64'(c_out_illegal), 64'(il64n));
    endtask

    logic [7:0]  exp_tag_q[$];
    logic [31:0] exp_imm_q[$];
    logic [11:0] imm12;
    logic [7:0]  next_tag;
    logic [7:0]  exp_tag;
    logic [31:0] exp_imm;
    logic [7:0]  held_tag;
    logic [31:0] held_imm;
    logic        prev_stall;
    logic        fired;

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_instr    = '0;
        in_imm_type = IMM_Z;
        in_tag      = '0;
        out_ready   = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out_imm", 64'(a_out_imm), 64'd0);
        check("rst_out_ill", 64'(a_out_illegal), 64'd0);
        check("rst_out_tag", 64'(a_out_tag), 64'd0);
        check("rst_b_valid", 64'(b_out_valid), 64'd0);
        rst_n = 1'b1;
        tick();

        // Directed format vectors.
        send_chk("i_neg1", IMM_I, 32'hFFF00093, 8'h5A,
                 64'hFFFFFFFF, 0, 64'hFFFFFFFFFFFFFFFF, 0, 64'hFFFFFFFFFFFFFFFF, 0);
        send_chk("u_neg", IMM_U, 32'h800000B7, 8'h01,
                 64'h80000000, 0, 64'hFFFFFFFF80000000, 0, 64'hFFFFFFFF80000000, 0);
        send_chk("csr21", IMM_CSR, 32'h000A8000, 8'h02, 64'd21, 0, 64'd21, 0, 64'd21, 0);
        send_chk("cj2", IMM_CJ, 32'h0000A009, 8'h03, 64'd2, 0, 64'd2, 0, 64'd0, 1);
        send_chk("s_neg1", IMM_S, 32'hFE000F80, 8'h04,
                 64'hFFFFFFFF, 0, 64'hFFFFFFFFFFFFFFFF, 0, 64'hFFFFFFFFFFFFFFFF, 0);
        send_chk("b_min", IMM_B, 32'h80000063, 8'h05,
                 64'hFFFFF000, 0, 64'hFFFFFFFFFFFFF000, 0, 64'hFFFFFFFFFFFFF000, 0);
        send_chk("j4", IMM_J, 32'h0040006F, 8'h06, 64'd4, 0, 64'd4, 0, 64'd4, 0);
        send_chk("ci_m32", IMM_CI, 32'h00001000, 8'h07,
                 64'hFFFFFFE0, 0, 64'hFFFFFFFFFFFFFFE0, 0, 64'd0, 1);
        send_chk("clui", IMM_CLUI, 32'h00000004, 8'h08, 64'h1000, 0, 64'h1000, 0, 64'd0, 1);
        send_chk("cb_m256", IMM_CB, 32'h00001000, 8'h09,
                 64'hFFFFFF00, 0, 64'hFFFFFFFFFFFFFF00, 0, 64'd0, 1);
        send_chk("z", IMM_Z, 32'hFFFFFFFF, 8'h0A, 64'd0, 0, 64'd0, 0, 64'd0, 0);
        send_chk("bad_type", imm_type_e'(4'd15), 32'hFFFFFFFF, 8'h0B, 64'd0, 1, 64'd0, 1, 64'd0, 1);
        tick();
        check("drain_valid", 64'(a_out_valid), 64'd0);

        // Backpressure: tags 1,2 accepted, 3 held, then released in order.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_imm_type = IMM_I;
        in_instr    = 32'h00100000;
        in_tag      = 8'd1;
        tick();
        in_tag = 8'd2;
        tick();
        check("bp_in_ready_low", 64'(a_in_ready), 64'd0);
        check("bp_head_tag", 64'(a_out_tag), 64'd1);
        in_tag = 8'd3;
        tick();
        check("bp_stall_valid", 64'(a_out_valid), 64'd1);
        check("bp_stall_tag", 64'(a_out_tag), 64'd1);
        check("bp_stall_imm", 64'(a_out_imm), 64'd1);
        out_ready = 1'b1;
        tick();
        $display("txn bp_release out_tag=%h in_ready=%0d", a_out_tag, a_in_ready);
        check("bp_second_tag", 64'(a_out_tag), 64'd2);
        check("bp_in_ready_back", 64'(a_in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_third_tag", 64'(a_out_tag), 64'd3);
        check("bp_third_valid", 64'(a_out_valid), 64'd1);
        tick();
        check("bp_empty", 64'(a_out_valid), 64'd0);

        // Flush with skid full and an input pending.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 8'h10;
        tick();
        in_tag = 8'h11;
        tick();
        in_tag = 8'h12;
        flush  = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        $display("txn flush_full out_valid=%0d in_ready=%0d", a_out_valid, a_in_ready);
        check("fl_out_valid", 64'(a_out_valid), 64'd0);
        check("fl_in_ready", 64'(a_in_ready), 64'd1);
        tick();
        check("fl_no_ghost", 64'(a_out_valid), 64'd0);

        // Flush while in_ready=1 drops the presented input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 8'h20;
        tick();
        in_tag = 8'h21;
        flush  = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        $display("txn flush_ready out_valid=%0d skid_ready=%0d", a_out_valid, a_in_ready);
        check("fl2_out_valid", 64'(a_out_valid), 64'd0);
        check("fl2_in_ready", 64'(a_in_ready), 64'd1);
        tick();
        check("fl2_no_ghost", 64'(a_out_valid), 64'd0);

        // Reset mid-stall with both registers occupied.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_instr    = 32'hFFF00093;
        in_tag      = 8'h30;
        tick();
        in_tag = 8'h31;
        tick();
        in_valid = 1'b0;
        check("rs_pre_valid", 64'(a_out_valid), 64'd1);
        check("rs_pre_full", 64'(a_in_ready), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        $display("txn reset_stall out_valid=%0d in_ready=%0d imm=%h", a_out_valid, a_in_ready, a_out_imm);
        check("rs_out_valid", 64'(a_out_valid), 64'd0);
        check("rs_in_ready", 64'(a_in_ready), 64'd1);
        check("rs_out_imm", 64'(a_out_imm), 64'd0);
        check("rs_out_tag", 64'(a_out_tag), 64'd0);
        check("rs_out_ill", 64'(a_out_illegal), 64'd0);

        // Random out_ready soak with scoreboard and stall-stability checks.
        next_tag   = 8'h40;
        prev_stall = 1'b0;
        held_tag   = '0;
        held_imm   = '0;
        in_imm_type = IMM_I;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (prev_stall && a_out_valid) begin
                check("soak_stable_tag", 64'(a_out_tag), 64'(held_tag));
                check("soak_stable_imm", 64'(a_out_imm), 64'(held_imm));
            end
            prev_stall = a_out_valid && !out_ready;
            held_tag   = a_out_tag;
            held_imm   = a_out_imm;
            if (a_out_valid && out_ready) begin
                if (exp_tag_q.size() == 0) begin
                    check("soak_unexpected_out", 64'(a_out_tag), 64'hFFFF);
                end else begin
                    exp_tag = exp_tag_q.pop_front();
                    exp_imm = exp_imm_q.pop_front();
                    $display("txn soak tag=%h imm=%h", a_out_tag, a_out_imm);
                    check("soak_tag", 64'(a_out_tag), 64'(exp_tag));
                    check("soak_imm", 64'(a_out_imm), 64'(exp_imm));
                end
            end
            fired = in_valid && a_in_ready;
            if (fired) begin
                imm12 = {in_tag, 4'hA};
                exp_tag_q.push_back(in_tag);
                exp_imm_q.push_back({{20{imm12[11]}}, imm12});
            end
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 2) != 0);
            if (!in_valid || fired) begin
                in_valid = (cyc < 380) && ($urandom_range(0, 3) != 0);
                if (in_valid) begin
                    in_tag   = next_tag;
                    in_instr = {next_tag, 4'hA, 20'h00013};
                    next_tag = next_tag + 8'd1;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (a_out_valid) begin
                if (exp_tag_q.size() == 0) begin
                    check("drain_unexpected_out", 64'(a_out_tag), 64'hFFFF);
                end else begin
                    exp_tag = exp_tag_q.pop_front();
                    exp_imm = exp_imm_q.pop_front();
                    check("drain_tag", 64'(a_out_tag), 64'(exp_tag));
                    check("drain_imm", 64'(a_out_imm), 64'(exp_imm));
                end
            end
        end
        check("soak_all_delivered", 64'(exp_tag_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
